// File: rtl/vend_dispenser.sv
// vend_dispenser: queues {vend, change} results and plays each one out as timed actuator pulses.
// Build macro VEND_COIN10_EN enables greedy 10-unit coins; without it all change leaves as 5s.
module vend_dispenser #(
   parameter int PULSE_W = 4,
   parameter int GAP_W   = 2,
   parameter int DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       vend,
   input  logic [2:0] change,
   output logic       prod_rel,
   output logic       coin10,
   output logic       coin5,
   output logic       busy,
   output logic       full,
   output logic       drop,
   output logic [2:0] fsm_state
);

   localparam int AW    = $clog2(DEPTH);
   localparam int MAXW  = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
   localparam int CNT_W = $clog2(MAXW) + 1;

   localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
   localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_W - 1);
   localparam logic [AW:0]      FULL_CNT = (AW + 1)'(DEPTH);
   localparam logic [AW:0]      ONE_CNT  = (AW + 1)'(1);
   localparam logic [AW-1:0]    ONE_PTR  = AW'(1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PROD = 3'd1,
      C10  = 3'd2,
      C5   = 3'd3,
      GAP  = 3'd4
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             vflag;
   logic [2:0]       rem;

   logic [3:0]       mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic [AW:0]      count_nxt;
   logic [3:0]       head;

   logic             capture;
   logic             push;
   logic             pop;
   logic             pulse_done;
   logic             gap_done;
   logic             load;
   state_t           sel_idle;
   state_t           sel_gap;
   state_t           enter_s;

   // Greedy order: product first, then 10s, then 5s; IDLE when nothing is owed.
   function automatic state_t sel_state(input logic vf, input logic [2:0] rm);
      if (vf) return PROD;
`ifdef VEND_COIN10_EN
      if (rm >= 3'd2) return C10;
`endif
      if (rm != 3'd0) return C5;
      return IDLE;
   endfunction

   // Upstream has no back-pressure: a qualifying cycle either lands in the FIFO or raises drop.
   assign capture    = vend | (change != 3'd0);
   assign push       = capture & (count != FULL_CNT);
   assign pop        = (state == IDLE) & (count != '0);
   assign head       = mem[rd_ptr];
   assign pulse_done = ((state == PROD) | (state == C10) | (state == C5)) & (cnt == '0);
   assign gap_done   = (state == GAP) & (cnt == '0);
   assign load       = pop | gap_done;
   assign sel_idle   = sel_state(head[3], head[2:0]);
   assign sel_gap    = sel_state(vflag, rem);
   assign enter_s    = pop ? sel_idle : sel_gap;
   assign fsm_state  = state;

   always_comb begin
      count_nxt = count;
      if (push && !pop) begin
         count_nxt = count + ONE_CNT;
      end else if (pop && !push) begin
         count_nxt = count - ONE_CNT;
      end
   end

   // Storage needs no reset: the pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {vend, change};
      end
   end

`ifndef VEND_COIN10_EN
   assign coin10 = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         vflag    <= 1'b0;
         rem      <= 3'd0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         prod_rel <= 1'b0;
         coin5    <= 1'b0;
`ifdef VEND_COIN10_EN
         coin10   <= 1'b0;
`endif
         busy     <= 1'b0;
         full     <= 1'b0;
         drop     <= 1'b0;
      end else begin
         count <= count_nxt;
         full  <= (count_nxt == FULL_CNT);
         drop  <= capture & ~push;
         if (push) begin
            wr_ptr <= wr_ptr + ONE_PTR;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + ONE_PTR;
         end

         case (state)
            IDLE: begin
               if (pop) begin
                  state <= sel_idle;
                  vflag <= head[3];
                  rem   <= head[2:0];
                  cnt   <= PULSE_LD;
                  busy  <= 1'b1;
               end else begin
                  busy  <= (count_nxt != '0);
               end
            end
            PROD, C10, C5: begin
               busy <= 1'b1;
               if (cnt == '0) begin
                  state <= GAP;
                  cnt   <= GAP_LD;
                  case (state)
                     PROD:    vflag <= 1'b0;
                     C10:     rem   <= rem - 3'd2;
                     default: rem   <= rem - 3'd1;
                  endcase
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            GAP: begin
               if (cnt == '0) begin
                  state <= sel_gap;
                  cnt   <= (sel_gap == IDLE) ? '0 : PULSE_LD;
                  busy  <= (sel_gap != IDLE) | (count_nxt != '0);
               end else begin
                  cnt  <= cnt - 1'b1;
                  busy <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
               busy  <= (count_nxt != '0);
            end
         endcase

         // Pulse outputs change only when a pulse state is entered or left.
         if (load) begin
            prod_rel <= (enter_s == PROD);
            coin5    <= (enter_s == C5);
`ifdef VEND_COIN10_EN
            coin10   <= (enter_s == C10);
`endif
         end else if (pulse_done) begin
            prod_rel <= 1'b0;
            coin5    <= 1'b0;
`ifdef VEND_COIN10_EN
            coin10   <= 1'b0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_vend_dispenser.sv
// tb_vend_dispenser: directed and random stimulus against a transaction-level model that
// expands each queued result into its per-cycle pulse sequence.
module tb_vend_dispenser;

   localparam int PULSE_W = 4;
   localparam int GAP_W   = 2;
   localparam int DEPTH   = 4;
`ifdef VEND_COIN10_EN
   localparam bit COIN10 = 1'b1;
`else
   localparam bit COIN10 = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       vend = 1'b0;
   logic [2:0] change = 3'd0;
   logic       prod_rel, coin10, coin5, busy, full, drop;
   logic [2:0] fsm_state;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int rel = 0;

   // Model: FIFO of {vend, change}; exp_q holds {prod, c10, c5} for each upcoming cycle.
   logic [3:0] fifo_m[$];
   logic [2:0] exp_q[$];
   logic       drop_m = 1'b0;

   int rise_p[$], rise_c10[$], rise_c5[$], drop_at[$];
   int busy_low_at, full_at;
   logic prev_p, prev_c10, prev_c5;

   vend_dispenser #(.PULSE_W(PULSE_W), .GAP_W(GAP_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .vend(vend), .change(change),
      .prod_rel(prod_rel), .coin10(coin10), .coin5(coin5),
      .busy(busy), .full(full), .drop(drop), .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic add_pulse(input logic [2:0] p);
      for (int i = 0; i < PULSE_W; i++) exp_q.push_back(p);
      for (int i = 0; i < GAP_W; i++) exp_q.push_back(3'b000);
   endtask

   task automatic expand(input logic [3:0] t);
      int ch, n10, n5;
      ch  = int'(t[2:0]);
      n10 = COIN10 ? ch / 2 : 0;
      n5  = ch - 2 * n10;
      if (t[3]) add_pulse(3'b100);
      for (int i = 0; i < n10; i++) add_pulse(3'b010);
      for (int i = 0; i < n5; i++) add_pulse(3'b001);
   endtask

   task automatic model_edge(input logic v, input logic [2:0] ch, input logic r);
      logic in_txn, cap, was_full;
      if (r) begin
         fifo_m.delete();
         exp_q.delete();
         drop_m = 1'b0;
         return;
      end
      in_txn   = (exp_q.size() != 0);
      cap      = v || (ch != 3'd0);
      was_full = (fifo_m.size() == DEPTH);
      if (in_txn) void'(exp_q.pop_front());
      else if (fifo_m.size() != 0) expand(fifo_m.pop_front());
      drop_m = cap && was_full;
      if (cap && !was_full) fifo_m.push_back({v, ch});
   endtask

   task automatic scenario_start();
      rel = 0;
      rise_p.delete(); rise_c10.delete(); rise_c5.delete(); drop_at.delete();
      busy_low_at = -1;
      full_at = -1;
      prev_p = 1'b0; prev_c10 = 1'b0; prev_c5 = 1'b0;
   endtask

   // Drive at the falling edge, model the rising edge, compare at the next falling edge.
   task automatic step(input logic v, input logic [2:0] ch, input logic r);
      logic [2:0] pv;
      logic       busy_m, full_m;
      vend = v; change = ch; rst = r;
      @(posedge clk);
      model_edge(v, ch, r);
      @(negedge clk);
      cyc++;
      rel++;
      pv     = (exp_q.size() != 0) ? exp_q[0] : 3'b000;
      busy_m = (exp_q.size() != 0) || (fifo_m.size() != 0);
      full_m = (fifo_m.size() == DEPTH);
      check_val("outs", {prod_rel, coin10, coin5, busy, full, drop}, {pv, busy_m, full_m, drop_m});
      check_val("onehot", ($countones({prod_rel, coin10, coin5}) <= 1), 1);
      check_val("fsm_idle", (fsm_state == 3'd0), (exp_q.size() == 0));
      if (prod_rel && !prev_p) rise_p.push_back(rel);
      if (coin10 && !prev_c10) rise_c10.push_back(rel);
      if (coin5 && !prev_c5) rise_c5.push_back(rel);
      if (!busy && busy_low_at < 0) busy_low_at = rel;
      if (full && full_at < 0) full_at = rel;
      if (drop) drop_at.push_back(rel);
      prev_p = prod_rel; prev_c10 = coin10; prev_c5 = coin5;
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 3'd0, 1'b0);
   endtask

   initial begin
      // Reset held 3 cycles with active inputs.
      scenario_start();
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 3'd5, 1'b1);
         check_val("rst_outs", {prod_rel, coin10, coin5, busy, full, drop}, 6'd0);
      end
      step(1'b0, 3'd0, 1'b0);
      check_val("rst_empty", {busy, full}, 2'b00);

      // Single vend.
      step(1'b0, 3'd0, 1'b1);
      scenario_start();
      step(1'b1, 3'd0, 1'b0);
      check_val("vend_busy1", busy, 1);
      idle_steps(11);
      check_val("vend_rise", (rise_p.size() == 1) ? rise_p[0] : -1, 2);
      check_val("vend_busy_low", busy_low_at, 8);

      // change = 3, with or without 10-unit coins.
      step(1'b0, 3'd0, 1'b1);
      scenario_start();
      if (COIN10) begin
         step(1'b1, 3'd3, 1'b0);
         idle_steps(23);
         check_val("c3_prod", (rise_p.size() == 1) ? rise_p[0] : -1, 2);
         check_val("c3_c10", (rise_c10.size() == 1) ? rise_c10[0] : -1, 8);
         check_val("c3_c5", (rise_c5.size() == 1) ? rise_c5[0] : -1, 14);
         check_val("c3_busy_low", busy_low_at, 20);
      end else begin
         step(1'b0, 3'd3, 1'b0);
         idle_steps(23);
         check_val("c3_n5", rise_c5.size(), 3);
         check_val("c3_c5a", (rise_c5.size() == 3) ? rise_c5[0] : -1, 2);
         check_val("c3_c5b", (rise_c5.size() == 3) ? rise_c5[1] : -1, 8);
         check_val("c3_c5c", (rise_c5.size() == 3) ? rise_c5[2] : -1, 14);
         check_val("c3_n10", rise_c10.size(), 0);
      end

      // Overflow: vend held for cycles 0-5.
      step(1'b0, 3'd0, 1'b1);
      scenario_start();
      for (int i = 0; i < 6; i++) step(1'b1, 3'd0, 1'b0);
      idle_steps(45);
      check_val("ovf_full_at", full_at, 5);
      check_val("ovf_drops", drop_at.size(), 1);
      check_val("ovf_drop_at", (drop_at.size() != 0) ? drop_at[0] : -1, 6);
      check_val("ovf_pulses", rise_p.size(), 5);

      // Reset in the middle of the first coin pulse with a full FIFO behind it.
      step(1'b0, 3'd0, 1'b1);
      scenario_start();
      step(1'b0, 3'd6, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 3'd0, 1'b0);
      check_val("pre_rst_c10", coin10, COIN10);
      check_val("pre_rst_pulse", coin10 | coin5, 1);
      check_val("pre_rst_full", full, 1);
      step(1'b0, 3'd0, 1'b1);
      check_val("mid_rst_c10", coin10, 0);
      check_val("mid_rst_busy", busy, 0);
      check_val("mid_rst_full", full, 0);
      scenario_start();
      idle_steps(30);
      check_val("post_rst_pulses", rise_p.size() + rise_c10.size() + rise_c5.size(), 0);

      // Random traffic with occasional resets.
      for (int i = 0; i < 900; i++) begin
         step(($urandom_range(0, 3) == 0),
              ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd0,
              ($urandom_range(0, 299) == 0));
      end
      idle_steps(120);
      check_val("drained_busy", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
